// File: rtl/i2c_mem_arbiter.sv
// i2c_mem_arbiter
// Shares one single-port synchronous memory between an I2C subordinate engine
// and a local host. I2C has fixed priority because SCL timing cannot be
// stretched. A small starvation counter lets the host win after I2C has been
// granted STARVE_LIMIT times in a row while the host was waiting.
//
// Each access takes exactly three cycles: IDLE (arbitrate and latch),
// ACCESS (drive the memory port), RESP (pulse the winner's ack and return
// read data). Everything the access needs is latched at grant, so a requester
// that changes or drops its inputs mid-access does not disturb it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i2c_req/we/addr/wdata         I2C-side request
//   i2c_ack, i2c_rdata            I2C completion pulse and read data
//   host_req/we/addr/wdata        host-side request
//   host_ack, host_rdata          host completion pulse and read data
//   mem_en/we/addr/wdata          memory port, mem_rdata valid one cycle after mem_en
//   busy                          high whenever not IDLE
//   owner                         0 = I2C, 1 = host (meaningful while busy)
module i2c_mem_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] LIMIT = STARVE_LIMIT[1:0];

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        starve_q, starve_d;
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_wins;
  logic              resp_live;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    i2c_rdata_d  = i2c_rdata_q;
    host_rdata_d = host_rdata_q;
    // Host wins when alone, or when I2C has used up its consecutive grants.
    host_wins    = host_req && (!i2c_req || (starve_q == LIMIT));

    unique case (state_q)
      IDLE: begin
        if (!host_req) begin
          starve_d = '0;
        end
        if (i2c_req || host_req) begin
          state_d = ACCESS;
          owner_d = host_wins;
          if (host_wins) begin
            we_d     = host_we;
            addr_d   = host_addr;
            wdata_d  = host_wdata;
            starve_d = '0;
          end else begin
            we_d    = i2c_we;
            addr_d  = i2c_addr;
            wdata_d = i2c_wdata;
            // Saturate so a limit of 3 can never wrap back to 0.
            if (host_req && (starve_q != 2'b11)) begin
              starve_d = starve_q + 2'd1;
            end
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        // Capture read data so rdata holds its value after the ack pulse.
        if (!we_q) begin
          if (owner_q) begin
            host_rdata_d = mem_rdata;
          end else begin
            i2c_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_q     <= '0;
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
      i2c_rdata_q  <= i2c_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // An access interrupted by reset while in RESP must not be acknowledged,
  // so the ack is suppressed in the very cycle reset is asserted.
  assign resp_live  = (state_q == RESP) && !rst;
  assign i2c_ack    = resp_live && !owner_q;
  assign host_ack   = resp_live && owner_q;
  assign i2c_rdata  = (i2c_ack && !we_q) ? mem_rdata : i2c_rdata_q;
  assign host_rdata = (host_ack && !we_q) ? mem_rdata : host_rdata_q;

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule
